// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the stack sequencer: operation codes, failure causes
// and controller states.
package stack_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_SETSP = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_TIMEOUT   = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_RANGE     = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive cycles spent waiting for a memory acknowledge and flags
// the cycle that would be the TIMEOUT-th one without a response.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Expired means the current waiting cycle is the last one allowed.
    assign expired = enable && (cnt_q >= LAST);

    // Next count: clear wins, otherwise advance while enabled (saturating).
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < LAST)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Burst push/pop sequencer for an empty-ascending word stack held in external
// memory. Bursts are range-checked before any memory access is issued.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  SP_BASE   = 16'h0100,
    parameter int unsigned        DEPTH     = 256,
    parameter int unsigned        MAX_BURST = 4,
    parameter int unsigned        TIMEOUT   = 15,
    localparam int unsigned       CW        = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] setData,
    input  logic [DATA_W-1:0] pushData,
    output logic              pushTake,
    output logic [DATA_W-1:0] popData,
    output logic              popValid,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        errCode,
    output logic [ADDR_W-1:0] sp
);

    // Stack window bounds, one bit wider than an address so sums never wrap.
    localparam logic [ADDR_W:0] SP_LO = {1'b0, SP_BASE};
    localparam logic [ADDR_W:0] SP_HI = SP_LO + (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [CW-1:0]       rem_q, rem_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0]   set_q, set_d;
    err_e                err_code_q, err_code_d;
    logic [DATA_W-1:0]   pop_data_q, pop_data_d;
    logic                pop_valid_q, pop_valid_d;

    logic                in_mem;
    logic                expired;
    logic [ADDR_W:0]     sp_ext, cnt_ext, set_ext;

    assign in_mem  = (state_q == ST_MEM_WR) || (state_q == ST_MEM_RD);
    assign sp_ext  = {1'b0, sp_q};
    assign cnt_ext = (ADDR_W + 1)'(rem_q);
    assign set_ext = {1'b0, set_q};

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_mem || memReady),
        .enable  (in_mem),
        .expired (expired)
    );

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        sp_d        = sp_q;
        set_d       = set_q;
        err_code_d  = err_code_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d       = op_e'(op);
                    rem_d      = count;
                    set_d      = setData;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                unique case (op_q)
                    OP_NOP: state_d = ST_DONE;
                    OP_SETSP: begin
                        if ((set_ext < SP_LO) || (set_ext > SP_HI)) begin
                            err_code_d = ERR_RANGE;
                            state_d    = ST_ERROR;
                        end else begin
                            sp_d    = set_q;
                            state_d = ST_DONE;
                        end
                    end
                    OP_PUSH: begin
                        if ((sp_ext + cnt_ext) > SP_HI) begin
                            err_code_d = ERR_OVERFLOW;
                            state_d    = ST_ERROR;
                        end else if (rem_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_MEM_WR;
                        end
                    end
                    OP_POP: begin
                        // sp - count < base, rearranged to avoid a negative result
                        if (sp_ext < (SP_LO + cnt_ext)) begin
                            err_code_d = ERR_UNDERFLOW;
                            state_d    = ST_ERROR;
                        end else if (rem_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_MEM_RD;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_MEM_WR: begin
                if (memReady) begin
                    sp_d  = sp_q + ADDR_W'(1);
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end else if (expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end
            end
            ST_MEM_RD: begin
                if (memReady) begin
                    pop_data_d  = memRData;
                    pop_valid_d = 1'b1;
                    sp_d        = sp_q - ADDR_W'(1);
                    rem_d       = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end else if (expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset returns to an empty-base idle stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            rem_q       <= '0;
            sp_q        <= SP_BASE;
            set_q       <= '0;
            err_code_q  <= ERR_TIMEOUT;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            sp_q        <= sp_d;
            set_q       <= set_d;
            err_code_q  <= err_code_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    // Memory-side and status outputs decoded from the registered state.
    always_comb begin
        memReq   = in_mem;
        memWe    = (state_q == ST_MEM_WR);
        memAddr  = '0;
        memWData = '0;
        if (state_q == ST_MEM_WR) begin
            memAddr  = sp_q;
            memWData = pushData;
        end else if (state_q == ST_MEM_RD) begin
            memAddr = sp_q - ADDR_W'(1);
        end
        pushTake = (state_q == ST_MEM_WR) && memReady;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        err      = (state_q == ST_ERROR);
        errCode  = err_code_q;
        popData  = pop_data_q;
        popValid = pop_valid_q;
        sp       = sp_q;
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a queue-based scoreboard and a
// small behavioural memory.
module tb_stack_sequencer;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  op;
    logic [2:0]  count;
    logic [15:0] setData;
    logic [15:0] pushData;
    logic        pushTake;
    logic [15:0] popData;
    logic        popValid;
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic [15:0] memRData;
    logic        memReady;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  errCode;
    logic [15:0] sp;

    stack_sequencer #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .SP_BASE   (16'h0100),
        .DEPTH     (8),
        .MAX_BURST (4),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .count    (count),
        .setData  (setData),
        .pushData (pushData),
        .pushTake (pushTake),
        .popData  (popData),
        .popValid (popValid),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memRData (memRData),
        .memReady (memReady),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .errCode  (errCode),
        .sp       (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [15:0] sp;
    } res_t;

    logic [31:0] exp_wr_q[$];   // {addr, data}
    logic [15:0] exp_rd_q[$];   // addr
    logic [15:0] exp_pop_q[$];  // data
    res_t        exp_res_q[$];

    // Memory model and acknowledge control.
    logic [15:0] mem [0:15];
    int          hs_cnt = 0;
    int          hs_limit = 1000000;
    int          memreq_cycles = 0;
    int          take_cnt = 0;
    logic [15:0] push_vals [0:31];
    logic [4:0]  push_idx = '0;

    assign memReady = memReq && (hs_cnt < hs_limit);
    assign memRData = mem[memAddr[3:0]];
    assign pushData = push_vals[push_idx];

    always @(posedge clk) begin
        if (memReq && memReady) begin
            hs_cnt <= hs_cnt + 1;
            if (memWe) mem[memAddr[3:0]] <= memWData;
        end
        if (pushTake) begin
            push_idx <= push_idx + 5'd1;
            take_cnt <= take_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_ev(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (memReq) memreq_cycles++;
            if (memReq && memReady) begin
                if (memWe) begin
                    if (exp_wr_q.size() == 0) fail_ev("write");
                    else begin
                        logic [31:0] e;
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", {16'h0, memAddr}, {16'h0, e[31:16]});
                        chk("wr_data", {16'h0, memWData}, {16'h0, e[15:0]});
                        chk("wr_take", {31'h0, pushTake}, 32'h1);
                    end
                end else begin
                    if (exp_rd_q.size() == 0) fail_ev("read");
                    else chk("rd_addr", {16'h0, memAddr}, {16'h0, exp_rd_q.pop_front()});
                end
            end
            if (popValid) begin
                if (exp_pop_q.size() == 0) fail_ev("pop");
                else chk("pop_data", {16'h0, popData}, {16'h0, exp_pop_q.pop_front()});
            end
            if (done || err) begin
                if (exp_res_q.size() == 0) fail_ev("result");
                else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    chk("res_kind", {30'h0, err, done}, {30'h0, r.is_err, !r.is_err});
                    if (r.is_err) chk("err_code", {30'h0, errCode}, {30'h0, r.code});
                    chk("res_sp", {16'h0, sp}, {16'h0, r.sp});
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [2:0] c, input logic [15:0] d);
        @(negedge clk);
        op = o; count = c; setData = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || err) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_ev({name, "_timeout"});
    endtask

    task automatic expect_res(input logic e, input logic [1:0] c, input logic [15:0] s);
        res_t r;
        r.is_err = e; r.code = c; r.sp = s;
        exp_res_q.push_back(r);
    endtask

    task automatic load_push(input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) push_vals[5'(push_idx + 5'(k))] = base + 16'(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int snap, take0;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        for (int k = 0; k < 32; k++) push_vals[k] = '0;
        rst = 1'b1; req = 1'b0; op = 2'b11; count = '0; setData = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_sp", {16'h0, sp}, 32'h0100);
        chk("rst_memreq", {31'h0, memReq}, 32'h0);
        chk("rst_flags", {28'h0, done, err, errCode}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // PUSH 3 words A1..A3
        load_push(3, 16'h00A1);
        exp_wr_q.push_back({16'h0100, 16'h00A1});
        exp_wr_q.push_back({16'h0101, 16'h00A2});
        exp_wr_q.push_back({16'h0102, 16'h00A3});
        expect_res(0, 2'b00, 16'h0103);
        take0 = take_cnt;
        issue(2'b00, 3'd3, 16'h0);
        wait_end("push3");
        @(negedge clk);
        chk("push3_takes", 32'(take_cnt - take0), 32'd3);

        // POP 2 words
        exp_rd_q.push_back(16'h0102);
        exp_rd_q.push_back(16'h0101);
        exp_pop_q.push_back(16'h00A3);
        exp_pop_q.push_back(16'h00A2);
        expect_res(0, 2'b00, 16'h0101);
        issue(2'b01, 3'd2, 16'h0);
        wait_end("pop2");
        @(negedge clk);

        // Overflow: sp=0x106 then PUSH 3
        expect_res(0, 2'b00, 16'h0106);
        issue(2'b10, 3'd0, 16'h0106);
        wait_end("setsp106");
        snap = memreq_cycles;
        expect_res(1, 2'b01, 16'h0106);
        issue(2'b00, 3'd3, 16'h0);
        wait_end("ovf");
        chk("ovf_noreq", 32'(memreq_cycles - snap), 32'd0);

        // Underflow: sp=0x101 then POP 2
        expect_res(0, 2'b00, 16'h0101);
        issue(2'b10, 3'd0, 16'h0101);
        wait_end("setsp101");
        snap = memreq_cycles;
        expect_res(1, 2'b10, 16'h0101);
        issue(2'b01, 3'd2, 16'h0);
        wait_end("unf");
        chk("unf_noreq", 32'(memreq_cycles - snap), 32'd0);

        // Timeout on second word of PUSH 2, with a req while busy
        expect_res(0, 2'b00, 16'h0100);
        issue(2'b10, 3'd0, 16'h0100);
        wait_end("setsp100");
        @(negedge clk);
        load_push(2, 16'h00B1);
        exp_wr_q.push_back({16'h0100, 16'h00B1});
        expect_res(1, 2'b00, 16'h0101);
        hs_limit = hs_cnt + 1;
        snap = memreq_cycles;
        issue(2'b00, 3'd2, 16'h0);
        @(negedge clk);
        @(negedge clk);
        op = 2'b11; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_end("tmo");
        chk("tmo_reqcyc", 32'(memreq_cycles - snap), 32'd5);
        @(negedge clk);
        chk("tmo_reqdrop", {31'h0, memReq}, 32'h0);
        chk("tmo_errhold", {30'h0, errCode}, 32'h0);
        hs_limit = 1000000;

        // SETSP out of range, then valid
        expect_res(1, 2'b11, 16'h0101);
        issue(2'b10, 3'd0, 16'h0200);
        wait_end("setsp200");
        @(negedge clk);
        chk("range_errhold", {30'h0, errCode}, 32'h3);
        expect_res(0, 2'b00, 16'h0104);
        issue(2'b10, 3'd0, 16'h0104);
        wait_end("setsp104");

        // NOP and zero-count PUSH complete without access
        snap = memreq_cycles;
        expect_res(0, 2'b00, 16'h0104);
        issue(2'b11, 3'd0, 16'h0);
        wait_end("nop");
        expect_res(0, 2'b00, 16'h0104);
        issue(2'b00, 3'd0, 16'h0);
        wait_end("push0");
        chk("zero_noreq", 32'(memreq_cycles - snap), 32'd0);

        // PUSH exactly up to the top of the window
        load_push(4, 16'h00D1);
        exp_wr_q.push_back({16'h0104, 16'h00D1});
        exp_wr_q.push_back({16'h0105, 16'h00D2});
        exp_wr_q.push_back({16'h0106, 16'h00D3});
        exp_wr_q.push_back({16'h0107, 16'h00D4});
        expect_res(0, 2'b00, 16'h0108);
        issue(2'b00, 3'd4, 16'h0);
        wait_end("pushfull");

        // Reset during a stalled write
        expect_res(0, 2'b00, 16'h0100);
        issue(2'b10, 3'd0, 16'h0100);
        wait_end("setsp100b");
        load_push(1, 16'h00C1);
        hs_limit = hs_cnt;
        issue(2'b00, 3'd1, 16'h0);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (memReq) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) fail_ev("rst_wait_memreq");
        end
        #3;
        rst = 1'b1;
        #1;
        chk("arst_memreq", {31'h0, memReq}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_sp", {16'h0, sp}, 32'h0100);
        @(negedge clk);
        rst = 1'b0;
        hs_limit = 1000000;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'h0, busy, memReq}, 32'h0);

        chk("q_wr_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("q_rd_pop_empty", 32'(exp_rd_q.size() + exp_pop_q.size()), 32'd0);
        chk("q_res_empty", 32'(exp_res_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_W, 16, word width; ADDR_W, 16, address width; SP_BASE, 16'h0100, lowest stack address; DEPTH, 256, stack capacity in words; MAX_BURST, 4, maximum words per request; TIMEOUT, 15, maximum wait cycles per memory access.
REQ-002 Ports (name direction width meaning) SHALL be, in order: clk in 1 clock; rst in 1 reset; req in 1 start pulse; op in 2 operation; count in CW=clog2(MAX_BURST+1) word count; setData in ADDR_W new SP value; pushData in DATA_W push word; pushTake out 1 push word consumed; popData out DATA_W popped word; popValid out 1 popData valid; memReq out 1 memory access request; memWe out 1 write enable; memAddr out ADDR_W address; memWData out DATA_W write data; memRData in DATA_W read data; memReady in 1 access complete; busy out 1 transaction active; done out 1 success pulse; err out 1 failure pulse; errCode out 2 failure cause; sp out ADDR_W stack pointer.
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 op encoding SHALL be: 00 PUSH, 01 POP, 10 SETSP, 11 NOP (completes with done, no access).
REQ-005 Stack SHALL be empty-ascending: PUSH writes at sp then sp+1; POP reads at sp-1 then sp-1.
REQ-006 States SHALL be IDLE, CHECK, MEM_WR, MEM_RD, DONE, ERROR.
REQ-007 IDLE: busy=0; req=1 latches op, count, setData; next state CHECK; req while busy SHALL be ignored.
REQ-008 CHECK (1 cycle): PUSH with sp+count > SP_BASE+DEPTH -> ERROR errCode=01 (overflow); POP with sp-count < SP_BASE -> ERROR errCode=10 (underflow); count=0 or NOP -> DONE; SETSP outside [SP_BASE, SP_BASE+DEPTH] -> ERROR errCode=11, else sp<=setData and DONE; otherwise MEM_WR (PUSH) or MEM_RD (POP).
REQ-009 Range checks SHALL be computed at ADDR_W+1 bits so no wrap-around; a failing burst SHALL perform zero memory accesses.
REQ-010 MEM_WR: memReq=1, memWe=1, memAddr=sp, memWData=pushData; on memReady: pushTake pulses that cycle, sp<=sp+1, remaining<=remaining-1; remaining reaching 0 -> DONE, else stay.
REQ-011 MEM_RD: memReq=1, memWe=0, memAddr=sp-1; on memReady: popData<=memRData, popValid=1 next cycle for one cycle, sp<=sp-1, remaining decremented; 0 -> DONE.
REQ-012 Wait counter SHALL clear at each access start and on memReady; TIMEOUT consecutive cycles without memReady -> ERROR errCode=00 (timeout), memReq deasserted next cycle, sp keeps completed words.
REQ-013 DONE and ERROR SHALL last one cycle, pulse done or err respectively, return to IDLE; errCode SHALL hold until next accepted req.
REQ-014 busy SHALL be 1 in every state except IDLE; memReq SHALL be 0 outside MEM_WR/MEM_RD.
REQ-015 memAddr, memWe, memWData SHALL be 0 when memReq=0.

Reset
REQ-016 rst SHALL immediately force state IDLE, sp=SP_BASE, remaining=0, wait counter=0, and all outputs 0, including mid-access (memReq drops asynchronously).

Structure
REQ-017 op encodings and errCode values SHALL live in the shared constants include file.
REQ-018 The wait counter SHALL be a sub-module wait_timer (clear, enable, expired output, TIMEOUT parameter).

Verification
REQ-019 Bench SHALL use SP_BASE=0x0100, DEPTH=8, MAX_BURST=4, TIMEOUT=4; scenarios:
- PUSH count=3 data 0xA1,0xA2,0xA3, memReady immediate -> writes at 0x100,0x101,0x102, 3 pushTake pulses, sp=0x103, done once.
- Then POP count=2 -> reads 0x102,0x101, popData 0xA3 then 0xA2, sp=0x101, done.
- sp=0x106, PUSH count=3 -> err, errCode=01, no memReq, sp=0x106; sp=0x101, POP count=2 -> errCode=10.
- PUSH count=2, memReady held low from second access -> first word written, err errCode=00 after 4 wait cycles, sp=0x101.
- SETSP 0x0200 -> errCode=11, sp unchanged; SETSP 0x0104 -> done, sp=0x104.
- rst asserted during MEM_WR wait -> memReq=0 same cycle, sp=0x100, busy=0; req during busy ignored.
